ff_share_arbiter: RTL

- Round-robin arbiter that shares a single registered stage (one WIDTH-bit flop plus valid bit) among N_REQ requesters.
- Each requester presents data with a valid/ready handshake; the winner's word is captured into the shared register and presented downstream with the requester ID.
- Sits in front of a shared flop-based datapath stage so several producers can time-multiplex it without combinational contention.

---
 rtl/ff_share_arbiter_if.sv | 29 ++
 rtl/ff_share_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/ff_share_arbiter_if.sv
// Handshake bundle between N_REQ requesters, the shared-register arbiter and
// the downstream consumer.
//   master : requesters + downstream consumer (drive req_valid/req_data/out_ready)
//   slave  : the arbiter (drives req_ready, out_valid/out_data/out_id, grant_count)
interface ff_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;
  logic [15:0]            grant_count;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, grant_count
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, grant_count
  );
endinterface

// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter sharing one registered stage (WIDTH-bit word + valid)
// among N_REQ valid/ready requesters. The winner's word is captured with its
// requester ID and presented downstream one cycle after acceptance.
// Ports:
//   CLK    : clock, all state updates on posedge
//   RESET  : synchronous active-high reset
//   bus    : ff_share_arbiter_if.slave
//            req_valid/req_data in, req_ready out (combinational),
//            out_valid/out_data/out_id out (registered), out_ready in,
//            grant_count out (registered, wrapping accept counter)
// Optional: define FF_SHARE_ARBITER_ASSERT_EN to compile in SVA checks.
module ff_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic               CLK,
  input logic               RESET,
  ff_share_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             can_load;
  logic             accept;

  // Round-robin search starting at rr_ptr with modulo-N_REQ wrap.
  always_comb begin
    int idx;
    win      = '0;
    win_data = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        win      = ID_W'(idx);
        win_data = bus.req_data[idx*int'(WIDTH) +: WIDTH];
      end
    end
  end

  // A drain and a load may share a cycle, so FULL only blocks when stalled.
  assign can_load = !bus.out_valid || bus.out_ready;
  assign accept   = can_load && found && !RESET;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready = N_REQ'(1) << win;
  end

  // Shared register, pointer and accept counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_id      <= '0;
      bus.grant_count <= '0;
      rr_ptr          <= '0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_data    <= win_data;
      bus.out_id      <= win;
      bus.grant_count <= bus.grant_count + 16'd1;
      rr_ptr          <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end else if (bus.out_valid && bus.out_ready) begin
      // Drained with nothing to load; data/id keep their last values.
      bus.out_valid <= 1'b0;
    end
  end

`ifdef FF_SHARE_ARBITER_ASSERT_EN
  a_onehot_ready: assert property (@(posedge CLK) disable iff (RESET)
    $onehot0(bus.req_ready));

  a_stall_hold: assert property (@(posedge CLK) disable iff (RESET)
    bus.out_valid && !bus.out_ready |=>
      $stable(bus.out_data) && $stable(bus.out_id) && bus.out_valid);

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_req_chk
    logic [ID_W:0] wait_q;

    a_load: assert property (@(posedge CLK) disable iff (RESET)
      bus.req_ready[g] |=>
        bus.out_data == $past(bus.req_data[g*WIDTH +: WIDTH]) &&
        bus.out_id == ID_W'(g));

    a_valid_held: assert property (@(posedge CLK) disable iff (RESET)
      bus.req_valid[g] && !bus.req_ready[g] |=> bus.req_valid[g]);

    // Cycles requester g has waited while downstream kept accepting.
    always_ff @(posedge CLK) begin
      if (RESET || !bus.req_valid[g] || bus.req_ready[g] || !bus.out_ready)
        wait_q <= '0;
      else
        wait_q <= wait_q + (ID_W+1)'(1);
    end

    a_bounded_grant: assert property (@(posedge CLK) disable iff (RESET)
      wait_q < (ID_W+1)'(N_REQ));
  end
`endif

endmodule
